// File: rtl/payout_manager.sv
// Bankroll and payout controller: validates wagers, settles hands through a payout table,
// and runs a capped high-low double-up loop. All outputs are registered.
module payout_manager #(
    parameter int unsigned MW          = 16,
    parameter int unsigned START_MONEY = 1000,
    parameter int unsigned MAX_DOUBLE  = 5,
    parameter int unsigned RW          = 3
) (
    input  logic          clock,
    input  logic          reset_c,
    input  logic          bet_c,
    input  logic [MW-1:0] wager_o,
    input  logic          hand_valid_c,
    input  logic [3:0]    hand_r,
    input  logic          dbl_c,
    input  logic          collect_c,
    input  logic          hl_valid_c,
    input  logic [1:0]    highlow_r,
    output logic [MW-1:0] money_r,
    output logic [MW-1:0] pending_r,
    output logic [1:0]    state_r,
    output logic [RW-1:0] round_r,
    output logic          bet_ack_r,
    output logic          bet_err_r,
    output logic          broke_r
);

    localparam int unsigned PW = MW + 7;
    localparam int unsigned SW = MW + 1;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWaitHand = 2'b01,
        StWin      = 2'b10,
        StDouble   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] money_q, money_d;
    logic [MW-1:0] pending_q, pending_d;
    logic [MW-1:0] stake_q, stake_d;
    logic [RW-1:0] round_q, round_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          broke_q, broke_d;

    logic [PW-1:0] prod_hand;
    logic [PW-1:0] prod_dbl;
    logic [SW-1:0] sum_money;

    function automatic logic [6:0] mult(input logic [3:0] rank);
        case (rank)
            4'b0010, 4'b0011: mult = 7'd1;
            4'b0100:          mult = 7'd2;
            4'b0101:          mult = 7'd4;
            4'b0110:          mult = 7'd5;
            4'b0111:          mult = 7'd10;
            4'b1000:          mult = 7'd15;
            4'b1001:          mult = 7'd50;
            4'b1010:          mult = 7'd100;
            default:          mult = 7'd0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        money_d   = money_q;
        pending_d = pending_q;
        stake_d   = stake_q;
        round_d   = round_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        prod_hand = PW'(stake_q) * PW'(mult(hand_r));
        prod_dbl  = PW'(pending_q) * PW'(2);
        sum_money = SW'(money_q) + SW'(pending_q);

        case (state_q)
            StIdle: begin
                if (bet_c) begin
                    if (wager_o != '0 && wager_o <= money_q) begin
                        money_d = money_q - wager_o;
                        stake_d = wager_o;
                        ack_d   = 1'b1;
                        state_d = StWaitHand;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWaitHand: begin
                if (hand_valid_c) begin
                    pending_d = (|prod_hand[PW-1:MW]) ? '1 : prod_hand[MW-1:0];
                    stake_d   = '0;
                    round_d   = '0;
                    state_d   = (pending_d == '0) ? StIdle : StWin;
                end
            end
            StWin: begin
                // Collect takes priority over a simultaneous double request.
                if (collect_c) begin
                    money_d   = sum_money[MW] ? '1 : sum_money[MW-1:0];
                    pending_d = '0;
                    round_d   = '0;
                    state_d   = StIdle;
                end else if (dbl_c && round_q < RW'(MAX_DOUBLE)) begin
                    state_d = StDouble;
                end
            end
            StDouble: begin
                if (hl_valid_c) begin
                    case (highlow_r)
                        2'b01: begin
                            pending_d = (|prod_dbl[PW-1:MW]) ? '1 : prod_dbl[MW-1:0];
                            round_d   = round_q + RW'(1);
                            state_d   = StWin;
                        end
                        2'b10: state_d = StWin;
                        2'b11: begin
                            pending_d = '0;
                            round_d   = '0;
                            state_d   = StIdle;
                        end
                        default: state_d = StDouble;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        broke_d = (state_d == StIdle) && (money_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset_c) begin
            state_q   <= StIdle;
            money_q   <= MW'(START_MONEY);
            pending_q <= '0;
            stake_q   <= '0;
            round_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            broke_q   <= (MW'(START_MONEY) == '0);
        end else begin
            state_q   <= state_d;
            money_q   <= money_d;
            pending_q <= pending_d;
            stake_q   <= stake_d;
            round_q   <= round_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            broke_q   <= broke_d;
        end
    end

    assign money_r   = money_q;
    assign pending_r = pending_q;
    assign state_r   = state_q;
    assign round_r   = round_q;
    assign bet_ack_r = ack_q;
    assign bet_err_r = err_q;
    assign broke_r   = broke_q;

endmodule

// File: tb/tb_payout_manager.sv
// Directed bench for payout_manager: three instances (default, large bankroll, small double cap)
// share one stimulus stream; each check targets the instance the scenario is written for.
module tb_payout_manager;

    logic        clock = 1'b0;
    logic        reset_c = 1'b1;
    logic        bet_c = 1'b0;
    logic [15:0] wager_o = '0;
    logic        hand_valid_c = 1'b0;
    logic [3:0]  hand_r = '0;
    logic        dbl_c = 1'b0;
    logic        collect_c = 1'b0;
    logic        hl_valid_c = 1'b0;
    logic [1:0]  highlow_r = '0;

    logic [15:0] a_money, a_pending, b_money, b_pending, c_money, c_pending;
    logic [1:0]  a_state, b_state, c_state;
    logic [2:0]  a_round, b_round, c_round;
    logic        a_ack, a_err, a_broke, b_ack, b_err, b_broke, c_ack, c_err, c_broke;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    payout_manager u_a (
        .clock(clock), .reset_c(reset_c), .bet_c(bet_c), .wager_o(wager_o),
        .hand_valid_c(hand_valid_c), .hand_r(hand_r), .dbl_c(dbl_c), .collect_c(collect_c),
        .hl_valid_c(hl_valid_c), .highlow_r(highlow_r), .money_r(a_money),
        .pending_r(a_pending), .state_r(a_state), .round_r(a_round), .bet_ack_r(a_ack),
        .bet_err_r(a_err), .broke_r(a_broke)
    );

    payout_manager #(.START_MONEY(60000)) u_b (
        .clock(clock), .reset_c(reset_c), .bet_c(bet_c), .wager_o(wager_o),
        .hand_valid_c(hand_valid_c), .hand_r(hand_r), .dbl_c(dbl_c), .collect_c(collect_c),
        .hl_valid_c(hl_valid_c), .highlow_r(highlow_r), .money_r(b_money),
        .pending_r(b_pending), .state_r(b_state), .round_r(b_round), .bet_ack_r(b_ack),
        .bet_err_r(b_err), .broke_r(b_broke)
    );

    payout_manager #(.MAX_DOUBLE(2)) u_c (
        .clock(clock), .reset_c(reset_c), .bet_c(bet_c), .wager_o(wager_o),
        .hand_valid_c(hand_valid_c), .hand_r(hand_r), .dbl_c(dbl_c), .collect_c(collect_c),
        .hl_valid_c(hl_valid_c), .highlow_r(highlow_r), .money_r(c_money),
        .pending_r(c_pending), .state_r(c_state), .round_r(c_round), .bet_ack_r(c_ack),
        .bet_err_r(c_err), .broke_r(c_broke)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
        bet_c = 1'b0;
        hand_valid_c = 1'b0;
        dbl_c = 1'b0;
        collect_c = 1'b0;
        hl_valid_c = 1'b0;
        reset_c = 1'b0;
    endtask

    task automatic do_reset();
        reset_c = 1'b1;
        step();
    endtask

    task automatic do_bet(input logic [15:0] w);
        bet_c = 1'b1;
        wager_o = w;
        step();
    endtask

    task automatic do_hand(input logic [3:0] r);
        hand_valid_c = 1'b1;
        hand_r = r;
        step();
    endtask

    task automatic do_hl(input logic [1:0] v);
        hl_valid_c = 1'b1;
        highlow_r = v;
        step();
    endtask

    task automatic do_dbl();
        dbl_c = 1'b1;
        step();
    endtask

    task automatic do_collect();
        collect_c = 1'b1;
        step();
    endtask

    initial begin
        // 1: reset state and a full flush / double / draw / collect hand
        do_reset();
        chk("rst_money", a_money, 1000);
        chk("rst_pending", a_pending, 0);
        chk("rst_state", a_state, 0);
        chk("rst_round", a_round, 0);
        chk("rst_ack", a_ack, 0);
        chk("rst_err", a_err, 0);
        chk("rst_broke", a_broke, 0);
        do_bet(16'd100);
        chk("t1_ack", a_ack, 1);
        chk("t1_err", a_err, 0);
        chk("t1_money", a_money, 900);
        chk("t1_state_wait", a_state, 1);
        step();
        chk("t1_ack_drop", a_ack, 0);
        do_hand(4'b0101);
        chk("t1_pending400", a_pending, 400);
        chk("t1_state_win", a_state, 2);
        chk("t1_round0", a_round, 0);
        do_dbl();
        chk("t1_state_dbl", a_state, 3);
        do_hl(2'b01);
        chk("t1_pending800", a_pending, 800);
        chk("t1_round1", a_round, 1);
        chk("t1_state_win2", a_state, 2);
        do_dbl();
        do_hl(2'b10);
        chk("t1_draw_pending", a_pending, 800);
        chk("t1_draw_round", a_round, 1);
        chk("t1_draw_state", a_state, 2);
        do_collect();
        chk("t1_money1700", a_money, 1700);
        chk("t1_pend_clr", a_pending, 0);
        chk("t1_state_idle", a_state, 0);
        chk("t1_round_clr", a_round, 0);

        // 2: rejected wagers, all-in bet, broke flag
        do_reset();
        do_bet(16'd1001);
        chk("t2_err_over", a_err, 1);
        chk("t2_ack_over", a_ack, 0);
        chk("t2_money_over", a_money, 1000);
        chk("t2_state_over", a_state, 0);
        do_bet(16'd0);
        chk("t2_err_zero", a_err, 1);
        chk("t2_money_zero", a_money, 1000);
        step();
        chk("t2_err_drop", a_err, 0);
        do_bet(16'd1000);
        chk("t2_ack_all", a_ack, 1);
        chk("t2_money0", a_money, 0);
        chk("t2_broke_wait", a_broke, 0);
        do_hand(4'b0000);
        chk("t2_state_idle", a_state, 0);
        chk("t2_pending0", a_pending, 0);
        chk("t2_broke", a_broke, 1);

        // 3: pair, double lost, out-of-state strobes ignored
        do_reset();
        do_bet(16'd100);
        do_hand(4'b0010);
        chk("t3_pending100", a_pending, 100);
        do_dbl();
        do_hl(2'b00);
        chk("t3_hold_state", a_state, 3);
        chk("t3_hold_pending", a_pending, 100);
        do_hl(2'b11);
        chk("t3_lose_pending", a_pending, 0);
        chk("t3_lose_money", a_money, 900);
        chk("t3_lose_state", a_state, 0);
        chk("t3_lose_round", a_round, 0);
        do_collect();
        do_hand(4'b1010);
        chk("t3_ignored_money", a_money, 900);
        chk("t3_ignored_state", a_state, 0);

        // 4: saturation on the payout and on the bankroll add (large bankroll instance)
        do_reset();
        chk("t4_rst_money", b_money, 60000);
        do_bet(16'd10000);
        chk("t4_ack", b_ack, 1);
        chk("t4_money", b_money, 50000);
        chk("t4_default_err", a_err, 1);
        do_hand(4'b1010);
        chk("t4_pending_sat", b_pending, 65535);
        do_collect();
        chk("t4_money_sat", b_money, 65535);
        chk("t4_state", b_state, 0);

        // 5: double-up cap of 2 and collect beating dbl
        do_reset();
        do_bet(16'd10);
        chk("t5_money", c_money, 990);
        do_hand(4'b0100);
        chk("t5_pending20", c_pending, 20);
        do_dbl();
        do_hl(2'b01);
        chk("t5_pending40", c_pending, 40);
        do_dbl();
        do_hl(2'b01);
        chk("t5_pending80", c_pending, 80);
        chk("t5_round2", c_round, 2);
        do_dbl();
        chk("t5_cap_state", c_state, 2);
        dbl_c = 1'b1;
        do_collect();
        chk("t5_money1070", c_money, 1070);
        chk("t5_state_idle", c_state, 0);
        chk("t5_pend_clr", c_pending, 0);

        // 6: reset during DOUBLE forfeits everything
        do_reset();
        do_bet(16'd100);
        do_hand(4'b0111);
        chk("t6_pending1000", a_pending, 1000);
        do_dbl();
        chk("t6_state_dbl", a_state, 3);
        do_reset();
        chk("t6_money", a_money, 1000);
        chk("t6_pending", a_pending, 0);
        chk("t6_state", a_state, 0);
        chk("t6_round", a_round, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
